weighted_rr_arbiter: RTL and testbench
======================================

Name: weighted_rr_arbiter

Overview:
- N-requester round-robin arbiter with per-channel weights and multi-cycle grant tenure. It is the successor of the team's single-cycle masked round-robin arbiter.
- The grant holds on one owner for up to weight[i] consumed cycles. An optional lock extends tenure.
- The grant is registered one-hot, with an encoded index alongside.
- Sits in front of shared buses and shared memory ports where masters need burst-fair access.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- WEIGHT_W, 4, bits per channel weight; max tenure is 2^WEIGHT_W-1 cycles.
- IDX_W, $clog2(N), width of grant_id. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request vector; bit i = requester i.
- weight  in  N*WEIGHT_W  per-channel weights; channel i occupies [i*WEIGHT_W +: WEIGHT_W].
- lock  in  1  current owner holds the grant past credit exhaustion.
- grant  out  N  registered one-hot grant.
- grant_valid  out  1  equals |grant.
- grant_id  out  IDX_W  index of the granted bit; 0 when grant_valid=0.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the environment): grant=0, grant_valid=0, grant_id=0, state=IDLE, pointer=0 (requester 0 highest priority), credit=0.
- States: IDLE (no owner) and OWN (owner g holds grant).
- IDLE, cycle t, req!=0:
  - Winner w = first set bit of req at or above pointer, wrapping to lowest set bit (masked / unmasked pick).
  - At t+1: grant=onehot(w), state OWN.
  - credit loaded with weight[w]; weight 0 is treated as 1. Weight is sampled only at tenure start.
- IDLE, req==0: stay IDLE, outputs 0.
- OWN, cycle t: grant[g] is consumed iff req[g]=1 in cycle t. Tenure ends after cycle t if either:
  - req[g]=0, or
  - the cycle is consumed, credit==1, and lock=0.
- OWN, tenure continues: a consumed cycle decrements credit, saturating at 1 while lock=1. grant is unchanged.
- Tenure end at cycle t:
  - pointer <= (g+1) mod N, so g becomes lowest priority.
  - Next winner is picked from req in cycle t using the new pointer. The owner's own req bit takes part at lowest priority.
  - If any request: grant switches at t+1 with no bubble cycle, and credit is reloaded.
  - If no request: grant=0 and state IDLE at t+1.
- Single requester with continuous req: re-granted back-to-back; each tenure reloads credit.
- Latency: req rises in IDLE at t, grant at t+1. Tenure end at t, next grant at t+1.
- Fairness: with all N requesting continuously, each channel receives exactly its weight (min 1) consumed cycles per round. Wait is bounded by the sum of the other channels' weights, unless lock is held.
- lock is ignored in IDLE. lock deasserting while credit==1 and the cycle is consumed ends tenure that cycle.
- weight changes mid-tenure have no effect until the next tenure start.
- Reset mid-tenure: outputs clear immediately (asynchronous); pointer returns to 0.
- Invariants: grant is always one-hot or zero; grant_id is consistent with grant; credit never 0 in OWN.

Decomposition:
- Package weighted_rr_arb_pkg:
  - state enum {IDLE, OWN};
  - localparams for the default N and WEIGHT_W;
  - function onehot_to_idx;
  - function rotate_mask (thermometer mask from pointer).
- Sub-module rr_priority_pick: combinational, parameter N.
  - Inputs: req and a one-hot/thermometer pointer mask.
  - Outputs: one-hot winner and any.
  - Uses the masked-then-unmasked fixed-priority scheme.
- The top module holds the FSM, credit counter, pointer and output registers.

Test Plan (N=4, WEIGHT_W=4):
- Reset: rst=1 with req=4'b1111 -> grant=0, grant_valid=0, grant_id=0. After release, the first grant is 0001 one cycle after req is sampled.
- Weights all 1, req=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, one per cycle, no bubbles; grant_id 0,1,2,3,0.
- Weights w0=2, w1=1, w2=3, w3=0, req=4'b1111 -> 0001 x2, 0010 x1, 0100 x3, 1000 x1 (weight 0 treated as 1), then repeat.
- Early release: w0=4, w1=2, req=0011; req[0] drops after 2 consumed cycles -> one unconsumed grant cycle on 0001, then 0010 for 2 cycles, then 0001 again with credit reloaded to 4.
- Lock: w1=1, req=0110, lock=1 for 5 cycles during owner 1 -> grant stays 0010 for 5 cycles. After lock drops, the next consumed cycle ends tenure and the grant moves to 0100.
- Reset mid-tenure: owner 2, credit 2 remaining, rst pulse -> grant=0 the same cycle. After release with req=0101, grant=0001 (pointer back to 0).

Source files
------------

// File: rtl/weighted_rr_arb_pkg.sv
// rtl/weighted_rr_arb_pkg.sv - shared types and helpers for the weighted round-robin arbiter
package weighted_rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_WEIGHT_W = 4;

  // OR-encoding is exact for a one-hot input and yields 0 for an all-zero input.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

  // Thermometer mask: every bit at or above ptr is set.
  function automatic logic [31:0] rotate_mask(input logic [4:0] ptr);
    return ~((32'd1 << ptr) - 32'd1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - masked-then-unmasked fixed-priority pick of the lowest set request
module rr_priority_pick
  import weighted_rr_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [N-1:0] winner,
  output logic         any
);

  logic [N-1:0] masked_req;

  // Isolating the lowest set bit with x & -x; the unmasked pick covers the wrap-around.
  always_comb begin
    masked_req = req & mask;
    if (|masked_req) winner = masked_req & (~masked_req + N'(1));
    else             winner = req & (~req + N'(1));
    any = |req;
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// rtl/weighted_rr_arbiter.sv - round-robin arbiter with per-channel weighted, lockable grant tenure
module weighted_rr_arbiter
  import weighted_rr_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  lock,
  output logic [N-1:0]          grant,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_id
);

  state_t               state, state_d;
  logic [IDX_W-1:0]     ptr, ptr_d, next_ptr, pick_ptr, id_d, win_idx;
  logic [WEIGHT_W-1:0]  credit, credit_d, win_weight, load_credit;
  logic [N-1:0]         grant_d, pick_mask, winner;
  logic                 owner_req, tenure_end, any;

  // On tenure end the pick already uses the advanced pointer so the switch has no bubble.
  always_comb begin
    owner_req  = |(req & grant);
    tenure_end = (state == OWN) &&
                 (!owner_req || ((credit == WEIGHT_W'(1)) && !lock));
    next_ptr   = (grant_id == IDX_W'(N - 1)) ? '0 : grant_id + IDX_W'(1);
    pick_ptr   = tenure_end ? next_ptr : ptr;
    pick_mask  = N'(rotate_mask(5'(pick_ptr)));
  end

  rr_priority_pick #(.N(N)) u_pick (
    .req    (req),
    .mask   (pick_mask),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    win_weight = '0;
    for (int i = 0; i < N; i++) begin
      if (winner[i]) win_weight = weight[i*WEIGHT_W +: WEIGHT_W];
    end
    load_credit = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
    win_idx     = IDX_W'(onehot_to_idx(32'(winner)));
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    id_d     = grant_id;
    credit_d = credit;
    ptr_d    = ptr;
    case (state)
      IDLE: begin
        if (any) begin
          state_d  = OWN;
          grant_d  = winner;
          id_d     = win_idx;
          credit_d = load_credit;
        end
      end
      OWN: begin
        if (tenure_end) begin
          ptr_d = next_ptr;
          if (any) begin
            grant_d  = winner;
            id_d     = win_idx;
            credit_d = load_credit;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            id_d     = '0;
            credit_d = '0;
          end
        end else if (owner_req && (credit != WEIGHT_W'(1))) begin
          // Locked tenure parks at credit 1 so the first unlocked consumed cycle ends it.
          credit_d = credit - WEIGHT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      credit   <= '0;
      ptr      <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      grant_id <= id_d;
      credit   <= credit_d;
      ptr      <= ptr_d;
    end
  end

  assign grant_valid = |grant;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb/tb_weighted_rr_arbiter.sv - self-checking bench for weighted_rr_arbiter
module tb_weighted_rr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*WW-1:0] weight = '0;
  logic            lock = 1'b0;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [1:0]      grant_id;

  int vectors = 0;
  int errors  = 0;

  int m_owner = -1;
  int m_credit = 0;
  int m_ptr = 0;

  weighted_rr_arbiter #(.N(N), .WEIGHT_W(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .weight      (weight),
    .lock        (lock),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst  = 1'b1;
    req  = '0;
    lock = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    m_owner = -1;
    m_credit = 0;
    m_ptr = 0;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int wt(input int c);
    int w;
    w = int'(weight[c*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  // Reference: owner tenure as a countdown of consumed cycles, next owner by rotating scan.
  task automatic model_step;
    int w;
    bit consumed, done;
    if (m_owner < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_credit = wt(w);
      end
    end else begin
      consumed = req[m_owner];
      done = !consumed || (m_credit == 1 && !lock);
      if (!done) begin
        if (consumed && m_credit > 1) m_credit--;
      end else begin
        m_ptr = (m_owner + 1) % N;
        w = pick(req, m_ptr);
        if (w >= 0) begin
          m_owner = w;
          m_credit = wt(w);
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'b1111;
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    #1;
    vectors++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: grant=%b valid=%b id=%0d, want 0000/0/0", grant, grant_valid, grant_id);
    end
    tick();
    vectors++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_held: grant=%b valid=%b id=%0d, want 0000/0/0", grant, grant_valid, grant_id);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_grant: grant=%b valid=%b id=%0d, want 0001/1/0", grant, grant_valid, grant_id);
    end
  endtask

  task automatic test_equal_weights;
    logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (grant !== exp_g[k] || grant_id !== 2'(k % N) || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL equal_weights[%0d]: grant=%b id=%0d valid=%b, want %b id=%0d", k, grant, grant_id, grant_valid, exp_g[k], k % N);
      end
    end
  endtask

  task automatic test_weighted_round;
    logic [N-1:0] exp_g [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100,
                                4'b0100, 4'b1000, 4'b0001, 4'b0001};
    do_reset();
    weight = {4'd0, 4'd3, 4'd1, 4'd2};
    req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      tick();
      vectors++;
      if (grant !== exp_g[k]) begin
        errors++;
        $display("FAIL weighted_round[%0d]: grant=%b, want %b", k, grant, exp_g[k]);
      end
    end
  endtask

  task automatic test_early_release;
    logic [N-1:0] req_s [10] = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0011,
                                 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    logic [N-1:0] exp_g [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    do_reset();
    weight = {4'd1, 4'd1, 4'd2, 4'd4};
    for (int k = 0; k < 10; k++) begin
      req = req_s[k];
      tick();
      vectors++;
      if (grant !== exp_g[k]) begin
        errors++;
        $display("FAIL early_release[%0d]: grant=%b, want %b", k, grant, exp_g[k]);
      end
    end
  endtask

  task automatic test_lock;
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b0110;
    for (int k = 0; k < 7; k++) begin
      lock = (k >= 1 && k <= 5);
      tick();
      vectors++;
      if (grant !== ((k < 6) ? 4'b0010 : 4'b0100)) begin
        errors++;
        $display("FAIL lock[%0d]: grant=%b, want %b", k, grant, (k < 6) ? 4'b0010 : 4'b0100);
      end
    end
    lock = 1'b0;
  endtask

  task automatic test_reset_mid_tenure;
    do_reset();
    weight = {4'd1, 4'd3, 4'd1, 4'd1};
    req = 4'b0001;
    tick();
    req = 4'b0100;
    tick();
    tick();
    vectors++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL mid_tenure_setup: grant=%b, want 0100", grant);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_tenure_async_clear: grant=%b valid=%b id=%0d, want 0000/0/0", grant, grant_valid, grant_id);
    end
    req = 4'b0101;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_tenure_ptr_reset: grant=%b id=%0d, want 0001 id=0", grant, grant_id);
    end
  endtask

  task automatic test_random;
    logic [N-1:0] eg;
    logic [1:0]   eid;
    do_reset();
    weight = 16'($urandom());
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) req = 4'($urandom());
      lock = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) weight = 16'($urandom());
      model_step();
      tick();
      eg = '0;
      eid = '0;
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        eid = 2'(m_owner);
      end
      vectors++;
      if (grant !== eg || grant_id !== eid || grant_valid !== (m_owner >= 0)) begin
        errors++;
        $display("FAIL random[%0d]: grant=%b id=%0d valid=%b, want %b id=%0d valid=%b",
                 i, grant, grant_id, grant_valid, eg, eid, (m_owner >= 0));
      end
    end
    lock = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal_weights();
    test_weighted_round();
    test_early_release();
    test_lock();
    test_reset_mid_tenure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
